// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit active-low 7-segment display with per-frame
// snapshot, leading-zero blanking, decimal points, PWM brightness and a ghosting guard.
module sev_seg_scan_driver #(
  parameter int unsigned CLK_DIV    = 25000,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PWM_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  input  logic [31:0]           disp_val,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  freeze,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            sev_out,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [DigW-1:0] DigMax = DigW'(NUM_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DigW-1:0]       digit_q, digit_d;
  logic [PWM_BITS-1:0]   phase_q, phase_d;
  logic [31:0]           snap_val_q, snap_val_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic                  snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            sev_q, sev_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  slot_tick;
  logic                  frame_end;
  logic [DigW-1:0]       lz_top;
  logic [3:0]            nibble;
  logic                  blanked;
  logic                  lit;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // Scan timing and snapshot next state
  always_comb begin
    slot_tick    = (cnt_q == CntMax);
    frame_end    = slot_tick && (digit_q == DigMax);
    cnt_d        = slot_tick ? '0 : cnt_q + 1'b1;
    digit_d      = digit_q;
    phase_d      = phase_q + 1'b1;
    snap_val_d   = snap_val_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    if (slot_tick) begin
      digit_d = (digit_q == DigMax) ? '0 : digit_q + 1'b1;
    end
    if (frame_end && !freeze) begin
      snap_val_d   = disp_val;
      snap_dp_d    = dp_mask;
      snap_blank_d = blank_lz;
    end
  end

  // Outputs are computed from next state so the registered pins line up with the
  // counters: guard at count 0, frame_done on the last cycle of the last slot.
  always_comb begin
    lz_top = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (snap_val_d[4*i +: 4] != 4'h0) lz_top = DigW'(i);
    end
    nibble  = snap_val_d[4*digit_d +: 4];
    blanked = snap_blank_d && (digit_d > lz_top);
    lit     = (cnt_d != '0) && !blanked &&
              ((brightness == '1) || (phase_d < brightness));
    an_d    = '1;
    if (lit) an_d[digit_d] = 1'b0;
    sev_d   = blanked ? 7'h7F : hex_glyph(nibble);
    dp_d    = blanked ? 1'b1 : ~snap_dp_d[digit_d];
    fd_d    = (cnt_d == CntMax) && (digit_d == DigMax);
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q        <= '0;
      digit_q      <= '0;
      phase_q      <= '0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= 1'b0;
      an_q         <= '1;
      sev_q        <= 7'h7F;
      dp_q         <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      phase_q      <= phase_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      sev_q        <= sev_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
    end
  end

  assign an         = an_q;
  assign sev_out    = sev_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Scoreboard bench for sev_seg_scan_driver (CLK_DIV=4, 8 digits): expectations are queued
// against cycle numbers since reset release and a negedge monitor pops and compares them.
module tb_sev_seg_scan_driver;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic [31:0] disp_val;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic        freeze;
  logic [7:0]  an;
  logic [6:0]  sev_out;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] an;
    bit         an_c;
    logic [6:0] sev;
    bit         sev_c;
    logic       dp;
    bit         dp_c;
    logic       fd;
    bit         fd_c;
  } exp_t;

  exp_t sb_q[$];

  // Hand-decoded glyphs: 89ABCDEF digits 0..7, 12345678 digits 0..7, 00000A05 digits 0..2
  logic [6:0] scan_g [8] = '{7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
                             7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000};
  logic [6:0] num_g  [8] = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
                             7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
  logic [6:0] blk_g  [3] = '{7'b0100100, 7'b0000001, 7'b0001000};
  localparam logic [6:0] Zero = 7'b0000001;

  sev_seg_scan_driver #(
    .CLK_DIV    (4),
    .NUM_DIGITS (8),
    .PWM_BITS   (4)
  ) dut (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .disp_val   (disp_val),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .freeze     (freeze),
    .an         (an),
    .sev_out    (sev_out),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] an_sel(input int k);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << k);
  endfunction

  function automatic logic [7:0] pwm_an(input int c, input int b);
    if ((c % 4 != 0) && (c % 16 < b)) return an_sel((c / 4) % 8);
    return 8'hFF;
  endfunction

  task automatic push(input int c, input string nm, input logic [7:0] a, input bit ac,
                      input logic [6:0] s, input bit sc, input logic d, input bit dc,
                      input logic f, input bit fc);
    exp_t e;
    int   idx;
    e = '{cyc: c, name: nm, an: a, an_c: ac, sev: s, sev_c: sc, dp: d, dp_c: dc,
          fd: f, fd_c: fc};
    idx = sb_q.size();
    while (idx > 0 && sb_q[idx-1].cyc > c) idx--;
    sb_q.insert(idx, e);
  endtask

  task automatic push_slot(input int c, input string nm, input logic [7:0] a,
                           input logic [6:0] s, input logic d);
    push(c, nm, a, 1'b1, s, 1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_an(input int c, input string nm, input logic [7:0] a);
    push(c, nm, a, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_dark(input int c, input string nm);
    push(c, nm, 8'hFF, 1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_fd(input int c, input string nm, input logic f);
    push(c, nm, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, f, 1'b1);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input int limit, input string nm);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expectations left, required 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: invariants every cycle plus queued expectations
  always @(negedge clk) begin : monitor
    exp_t e;
    if (Rst_n) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d an=%h, required at most one low bit", cyc, an);
      end
      if (cyc % 4 == 0) begin
        checks++;
        if (an !== 8'hFF) begin
          errors++;
          $display("FAIL guard cyc=%0d an=%h, required ff", cyc, an);
        end
      end
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: missed cyc %0d (now %0d)", e.name, e.cyc, cyc);
        end else if ((e.an_c && an !== e.an) || (e.sev_c && sev_out !== e.sev) ||
                     (e.dp_c && dp !== e.dp) || (e.fd_c && frame_done !== e.fd)) begin
          errors++;
          $display("FAIL %s cyc=%0d an=%h/%h sev=%b/%b dp=%b/%b fd=%b/%b (actual/required)",
                   e.name, cyc, an, e.an, sev_out, e.sev, dp, e.dp, frame_done, e.fd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n      = 1'b0;
    disp_val   = 32'h89AB_CDEF;
    dp_mask    = 8'h00;
    blank_lz   = 1'b0;
    brightness = 4'hF;
    freeze     = 1'b0;

    // Reset outputs, first anode, frame_done cadence, full scan of 89ABCDEF in frame 1
    push(0, "rst_out", 8'hFF, 1'b1, 7'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    push_slot(1, "first_an", 8'hFE, Zero, 1'b1);
    push_fd(30, "fd_lo", 1'b0);
    push_fd(31, "fd_hi0", 1'b1);
    push_fd(32, "fd_lo", 1'b0);
    push_fd(62, "fd_lo", 1'b0);
    push_fd(63, "fd_hi1", 1'b1);
    push_fd(64, "fd_lo", 1'b0);
    push_fd(95, "fd_hi2", 1'b1);
    for (int k = 0; k < 8; k++) begin
      push_slot(32 + 4*k, "scan_guard", 8'hFF, scan_g[k], 1'b1);
      push_slot(33 + 4*k, "scan", an_sel(k), scan_g[k], 1'b1);
    end
    repeat (3) @(posedge clk);
    #2 Rst_n = 1'b1;

    // Mid-frame change: frame 1 keeps 89ABCDEF, frame 2 blanks above digit 2
    at_cyc(40);
    blank_lz = 1'b1;
    disp_val = 32'h0000_0A05;
    for (int k = 0; k < 8; k++) begin
      if (k <= 2) push_slot(65 + 4*k, "blank_lit", an_sel(k), blk_g[k], 1'b1);
      else        push_dark(65 + 4*k, "blank_dark");
    end

    at_cyc(72);
    disp_val = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) push_slot(97, "zero_d0", 8'hFE, Zero, 1'b1);
      else        push_dark(97 + 4*k, "zero_dark");
    end

    // Freeze holds the zero/blank snapshot for two frames
    at_cyc(100);
    disp_val = 32'h1234_5678;
    freeze   = 1'b1;
    blank_lz = 1'b0;
    push_slot(129, "frz_d0", 8'hFE, Zero, 1'b1);
    push_dark(133, "frz_d1");
    push_slot(161, "frz_d0b", 8'hFE, Zero, 1'b1);
    push_dark(173, "frz_d3");

    at_cyc(170);
    freeze = 1'b0;
    for (int k = 0; k < 8; k++) push_slot(193 + 4*k, "unfrz", an_sel(k), num_g[k], 1'b1);

    // Decimal points on digits 0 and 7, already present in the guard cycle
    at_cyc(200);
    dp_mask = 8'h81;
    push_slot(224, "dp_guard", 8'hFF, num_g[0], 1'b0);
    for (int k = 0; k < 8; k++)
      push_slot(225 + 4*k, "dp", an_sel(k), num_g[k], (k == 0 || k == 7) ? 1'b0 : 1'b1);

    // PWM: brightness 4 then 6 (live), then 0 keeps every anode off
    at_cyc(255);
    brightness = 4'd4;
    for (int c = 256; c < 288; c++) push_an(c, "pwm", pwm_an(c, (c < 272) ? 4 : 6));
    at_cyc(271);
    brightness = 4'd6;
    at_cyc(288);
    brightness = 4'd0;
    for (int c = 289; c <= 320; c++) push_an(c, "pwm_off", 8'hFF);
    at_cyc(321);
    brightness = 4'hF;
    drain(200, "drain_main");

    // Asynchronous reset mid-slot: outputs dark without waiting for an edge
    at_cyc(330);
    @(posedge clk);
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF || sev_out !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst an=%h/ff sev=%b/1111111 dp=%b/1 fd=%b/0 (actual/required)",
               an, sev_out, dp, frame_done);
    end
    push(0, "rst2_out", 8'hFF, 1'b1, 7'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    push_slot(1, "rst2_first", 8'hFE, Zero, 1'b1);
    push_slot(4, "rst2_guard", 8'hFF, Zero, 1'b1);
    push_slot(5, "rst2_d1", 8'hFD, Zero, 1'b1);
    repeat (3) @(posedge clk);
    #2 Rst_n = 1'b1;
    drain(100, "drain_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
